sipo_deserializer: RTL and testbench

- Serial-in, parallel-out receive stage that sits directly downstream of the 4-bit PISO shift register.
- Accumulates a bit stream into WIDTH-bit words and presents each completed word on a valid/ready parallel port.
- A start input provides frame alignment.
- A sticky overrun flag reports words dropped under backpressure.

---
 rtl/sipo_deserializer.sv | 162 ++++++++++++++++
 tb/tb_sipo_deserializer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// sipo_deserializer
// Serial-in, parallel-out receive stage. Collects a serial bit stream into
// WIDTH-bit words and offers each completed word on a valid/ready port.
// A start strobe realigns framing, and a sticky overrun flag records any
// completed word that had to be dropped because the holding register was
// still occupied.

module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             start,
    output logic [WIDTH-1:0] pout_data,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic [CW-1:0]    bit_cnt
);

    // IDLE holds no partial word; SHIFT holds between 1 and WIDTH-1 bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shift_base;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_next;

    logic             first_bit;
    logic             last_bit;
    logic             complete;
    logic             hold_free;
    logic             load_word;
    logic             drop_word;

    // Classify the current serial beat: a fresh word start, the final bit
    // of a word, or an ordinary middle bit.
    always_comb begin
        first_bit = 1'b0;
        last_bit  = 1'b0;
        complete  = 1'b0;
        if (sin_valid) begin
            first_bit = (state == IDLE) || start;
            last_bit  = (bit_cnt == CW'(WIDTH - 1));
            complete  = (state == SHIFT) && !start && last_bit;
        end
    end

    // Next-state logic: a start strobe while shifting keeps us in SHIFT but
    // restarts the count, so it is handled by the datapath rather than here.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sin_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (complete) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift datapath. A first bit shifts into a cleared register so that a
    // resync leaves no trace of the abandoned partial word.
    always_comb begin
        shift_base = first_bit ? '0 : shreg;
        if (MSB_FIRST) begin
            shifted = {shift_base[WIDTH-2:0], sin_data};
        end else begin
            shifted = {sin_data, shift_base[WIDTH-1:1]};
        end

        shreg_next = shreg;
        cnt_next   = bit_cnt;
        if (sin_valid) begin
            if (complete) begin
                shreg_next = '0;
                cnt_next   = '0;
            end else if (first_bit) begin
                shreg_next = shifted;
                cnt_next   = CW'(1);
            end else begin
                shreg_next = shifted;
                cnt_next   = bit_cnt + CW'(1);
            end
        end
    end

    // Holding-register arbitration: a completed word may be loaded when the
    // register is empty or being drained on this very edge; otherwise it
    // is lost and the overrun flag records that.
    always_comb begin
        hold_free = !pout_valid || pout_ready;
        load_word = complete && hold_free;
        drop_word = complete && !hold_free;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Partial-word shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            shreg   <= shreg_next;
            bit_cnt <= cnt_next;
        end
    end

    // Output holding register and its valid flag. A load takes priority
    // over a plain drain so back-to-back words leave no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pout_data  <= '0;
            pout_valid <= 1'b0;
        end else if (load_word) begin
            pout_data  <= shifted;
            pout_valid <= 1'b1;
        end else if (pout_valid && pout_ready) begin
            pout_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop_word) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer
// Drives an MSB-first and an LSB-first deserializer from the same serial
// stream and scoreboards every accepted word against queued expectations.

module tb_sipo_deserializer;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sin_valid;
    logic             sin_data;
    logic             start;
    logic             pout_ready;
    logic             overrun_clr;

    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_overrun;
    logic [CW-1:0]    m_cnt;

    logic [WIDTH-1:0] l_data;
    logic             l_valid;
    logic             l_overrun;
    logic [CW-1:0]    l_cnt;

    int               checks     = 0;
    int               failures   = 0;
    int               words_seen = 0;
    int               words_mark;

    logic [WIDTH-1:0] msb_q[$];
    logic [WIDTH-1:0] lsb_q[$];

    sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin_valid   (sin_valid),
        .sin_data    (sin_data),
        .start       (start),
        .pout_data   (m_data),
        .pout_valid  (m_valid),
        .pout_ready  (pout_ready),
        .overrun     (m_overrun),
        .overrun_clr (overrun_clr),
        .bit_cnt     (m_cnt)
    );

    sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin_valid   (sin_valid),
        .sin_data    (sin_data),
        .start       (start),
        .pout_data   (l_data),
        .pout_valid  (l_valid),
        .pout_ready  (pout_ready),
        .overrun     (l_overrun),
        .overrun_clr (overrun_clr),
        .bit_cnt     (l_cnt)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Words listed in send order: an MSB-first receiver reproduces them,
    // an LSB-first receiver sees them bit-reversed.
    task automatic pushWord(input logic [WIDTH-1:0] bits);
        msb_q.push_back(bits);
        lsb_q.push_back(rev(bits));
    endtask

    task automatic applyStimulus(input logic b, input logic st);
        @(posedge clk);
        #2;
        sin_valid = 1'b1;
        sin_data  = b;
        start     = st;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #2;
        sin_valid = 1'b0;
        sin_data  = 1'b0;
        start     = 1'b0;
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] bits);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            applyStimulus(bits[i], 1'b0);
        end
    endtask

    // Scoreboard monitor: on the falling edge, a valid word with ready high
    // will be taken on the next rising edge, so compare it now.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && pout_ready === 1'b1) begin
            if (m_valid === 1'b1) begin
                words_seen++;
                if (msb_q.size() == 0) begin
                    checkOutput("msb_unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("msb_word", 32'(m_data), 32'(msb_q.pop_front()));
                end
            end
            if (l_valid === 1'b1) begin
                if (lsb_q.size() == 0) begin
                    checkOutput("lsb_unexpected_word", 32'(l_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("lsb_word", 32'(l_data), 32'(lsb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        sin_valid   = 1'b0;
        sin_data    = 1'b0;
        start       = 1'b0;
        pout_ready  = 1'b1;
        overrun_clr = 1'b0;

        // Reset state
        #1;
        checkOutput("rst_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_data", 32'(m_data), 32'd0);
        checkOutput("rst_overrun", 32'(m_overrun), 32'd0);
        checkOutput("rst_cnt", 32'(m_cnt), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Basic word, MSB-first: 1,0,1,0 -> 1010
        pushWord(4'b1010);
        sendWord(4'b1010);
        idleCycle();
        checkOutput("basic_valid", 32'(m_valid), 32'd1);
        checkOutput("basic_data", 32'(m_data), 32'hA);
        checkOutput("basic_cnt", 32'(m_cnt), 32'd0);
        checkOutput("basic_overrun", 32'(m_overrun), 32'd0);
        idleCycle();
        checkOutput("basic_valid_drop", 32'(m_valid), 32'd0);

        // Back-to-back words with no gap bits
        words_mark = words_seen;
        pushWord(4'b1010);
        pushWord(4'b1011);
        pushWord(4'b1110);
        pushWord(4'b1111);
        sendWord(4'b1010);
        sendWord(4'b1011);
        sendWord(4'b1110);
        sendWord(4'b1111);
        idleCycle();
        checkOutput("b2b_last_valid", 32'(m_valid), 32'd1);
        idleCycle();
        idleCycle();
        checkOutput("b2b_word_count", 32'(words_seen - words_mark), 32'd4);
        checkOutput("b2b_overrun", 32'(m_overrun), 32'd0);

        // Backpressure: second word is dropped and overrun set
        pout_ready = 1'b0;
        pushWord(4'b1010);
        sendWord(4'b1010);
        sendWord(4'b0110);
        idleCycle();
        checkOutput("bp_hold_data", 32'(m_data), 32'hA);
        checkOutput("bp_hold_lsb_data", 32'(l_data), 32'h5);
        checkOutput("bp_hold_valid", 32'(m_valid), 32'd1);
        checkOutput("bp_overrun", 32'(m_overrun), 32'd1);
        checkOutput("bp_lsb_overrun", 32'(l_overrun), 32'd1);
        pout_ready = 1'b1;
        idleCycle();
        checkOutput("bp_drained", 32'(m_valid), 32'd0);
        checkOutput("bp_overrun_sticky", 32'(m_overrun), 32'd1);
        overrun_clr = 1'b1;
        idleCycle();
        overrun_clr = 1'b0;
        checkOutput("bp_overrun_clr", 32'(m_overrun), 32'd0);

        // Completion on the same edge as a drain: no overrun
        pout_ready = 1'b0;
        pushWord(4'b1110);
        pushWord(4'b0011);
        sendWord(4'b1110);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        pout_ready = 1'b1;
        idleCycle();
        checkOutput("drain_load_valid", 32'(m_valid), 32'd1);
        checkOutput("drain_load_data", 32'(m_data), 32'h3);
        checkOutput("drain_load_overrun", 32'(m_overrun), 32'd0);
        idleCycle();

        // Resync: 1,1 then start on 0, then 1,1,0 -> 0110
        pushWord(4'b0110);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("resync_cnt_before", 32'(m_cnt), 32'd2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("resync_cnt_after", 32'(m_cnt), 32'd1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        idleCycle();
        checkOutput("resync_data", 32'(m_data), 32'h6);
        checkOutput("resync_overrun", 32'(m_overrun), 32'd0);
        idleCycle();

        // LSB-first: 1,0,1,1 -> 1101 (MSB-first sees 1011)
        msb_q.push_back(4'b1011);
        lsb_q.push_back(4'b1101);
        sendWord(4'b1011);
        idleCycle();
        checkOutput("lsb_first_data", 32'(l_data), 32'hD);
        checkOutput("msb_first_data", 32'(m_data), 32'hB);
        idleCycle();

        // Asynchronous reset with a held word, an overrun and a partial word
        pout_ready = 1'b0;
        pushWord(4'b1100);
        sendWord(4'b1100);
        sendWord(4'b0011);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        idleCycle();
        checkOutput("pre_rst_cnt", 32'(m_cnt), 32'd2);
        checkOutput("pre_rst_overrun", 32'(m_overrun), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(m_valid), 32'd0);
        checkOutput("async_rst_data", 32'(m_data), 32'd0);
        checkOutput("async_rst_overrun", 32'(m_overrun), 32'd0);
        checkOutput("async_rst_cnt", 32'(m_cnt), 32'd0);
        checkOutput("async_rst_lsb_valid", 32'(l_valid), 32'd0);
        msb_q.delete();
        lsb_q.delete();
        @(posedge clk);
        #2;
        rst_n      = 1'b1;
        pout_ready = 1'b1;
        pushWord(4'b1001);
        sendWord(4'b1001);
        idleCycle();
        checkOutput("post_rst_data", 32'(m_data), 32'h9);
        checkOutput("post_rst_valid", 32'(m_valid), 32'd1);
        idleCycle();
        idleCycle();

        // Every expected word must have been delivered
        checkOutput("msb_queue_empty", 32'(msb_q.size()), 32'd0);
        checkOutput("lsb_queue_empty", 32'(lsb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
